// File: rtl/rice_sample_serializer.sv
// Streams reconstructed J-sample blocks out one sample per cycle over valid/ready,
// with an active + pending block buffer for bubble-free back-to-back blocks.
module rice_sample_serializer #(
  parameter int SAMPLE_W = 10,
  parameter int J_MAX    = 32,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                j,
  input  logic [SAMPLE_W*J_MAX-1:0] blk_data,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  output logic [SAMPLE_W-1:0]       smp_data,
  output logic                      smp_valid,
  output logic                      smp_last,
  input  logic                      smp_ready,
  output logic [SAMPLE_W-1:0]       xref_out,
  output logic [CNT_W-1:0]          blk_count,
  output logic                      overrun,
  output logic                      err_j
);

  localparam int BLK_W = SAMPLE_W * J_MAX;
  localparam int IDX_W = (J_MAX > 1) ? $clog2(J_MAX) : 1;
  localparam int LEN_W = $clog2(J_MAX + 1);
  localparam logic [5:0]       J_MAX_J   = 6'(J_MAX);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(J_MAX);

  typedef enum logic [1:0] {
    EMPTY,
    STREAM,
    STREAM_PEND
  } state_t;

  state_t state_q, state_d;

  logic [BLK_W-1:0]    act_data_q;
  logic [LEN_W-1:0]    act_len_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BLK_W-1:0]    pend_data_q;
  logic [LEN_W-1:0]    pend_len_q;
  logic [SAMPLE_W-1:0] xref_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                overrun_q;
  logic                err_j_q;

  logic                j_bad;
  logic [LEN_W-1:0]    len_in;
  logic                accept;
  logic                xfer;
  logic                done;
  logic                ld_act_in;
  logic                ld_act_pend;
  logic                ld_pend;

  // Out-of-range lengths are clamped to a full block and flagged.
  assign j_bad  = (j == 6'd0) || (j > J_MAX_J);
  assign len_in = j_bad ? LEN_MAX : LEN_W'(j);

  assign accept = blk_valid & blk_ready;
  assign xfer   = smp_valid & smp_ready;
  assign done   = xfer & smp_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_act_in   = 1'b0;
    ld_act_pend = 1'b0;
    ld_pend     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = STREAM;
          ld_act_in = 1'b1;
        end
      end
      STREAM: begin
        // A block finishing on the same edge as an accept frees active directly.
        if (done) begin
          if (accept) begin
            ld_act_in = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end else if (accept) begin
          state_d = STREAM_PEND;
          ld_pend = 1'b1;
        end
      end
      STREAM_PEND: begin
        if (done) begin
          state_d     = STREAM;
          ld_act_pend = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    blk_ready = (state_q != STREAM_PEND);
    smp_valid = (state_q != EMPTY);
    smp_data  = smp_valid ? act_data_q[SAMPLE_W*idx_q +: SAMPLE_W] : '0;
    smp_last  = smp_valid && (LEN_W'(idx_q) == (act_len_q - LEN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_data_q  <= '0;
      act_len_q   <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_len_q  <= '0;
      xref_q      <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      err_j_q     <= 1'b0;
    end else begin
      if (ld_act_in) begin
        act_data_q <= blk_data;
        act_len_q  <= len_in;
        idx_q      <= '0;
      end else if (ld_act_pend) begin
        act_data_q <= pend_data_q;
        act_len_q  <= pend_len_q;
        idx_q      <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (ld_pend) begin
        pend_data_q <= blk_data;
        pend_len_q  <= len_in;
      end
      if (xfer) begin
        xref_q <= smp_data;
      end
      if (done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (blk_valid && !blk_ready) begin
        overrun_q <= 1'b1;
      end
      if (accept && j_bad) begin
        err_j_q <= 1'b1;
      end
    end
  end

  assign xref_out  = xref_q;
  assign blk_count = cnt_q;
  assign overrun   = overrun_q;
  assign err_j     = err_j_q;

endmodule
